xslv_sram_responder: RTL and testbench

- Slave-side responder endpoint for one fabric slave port: it is the target of the req/rsp handshake that the slave translator drives.
- Accepts read/write requests, performs byte-strobed accesses on an internal register-array memory and returns exactly one response per request, in order.
- Has a programmable access latency and bounded outstanding depth.
- Used as the RAM/ROM/scratch target in fabric-level benches and as a small on-chip scratchpad.

---
 rtl/xfab_pkg.sv | 23 ++
 rtl/xfab_sync_fifo.sv | 67 ++++++
 rtl/xslv_sram_responder.sv | 131 +++++++++++++
 tb/tb_xslv_sram_responder.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xfab_pkg.sv
// Shared fabric definitions: default widths, strobe-width helper and the
// response/pipeline entry shapes used by the slave responders.
package xfab_pkg;

  localparam int DEF_AW          = 16;
  localparam int DEF_DW          = 16;
  localparam int MAX_LATENCY     = 4;
  localparam int MAX_OUTSTANDING = 8;

  function automatic int strb_w(input int dw);
    return dw / 8;
  endfunction

  typedef struct packed {
    logic [DEF_DW-1:0] dat;
  } rsp_entry_t;

  typedef struct packed {
    logic              vld;
    logic [DEF_DW-1:0] dat;
  } pipe_entry_t;

endpackage

// File: rtl/xfab_sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through head; push and pop may
// coincide even when full.
module xfab_sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/xslv_sram_responder.sv
// Fabric slave responder: byte-strobed register-array memory with a fixed
// access latency, bounded outstanding requests and in-order responses.
module xslv_sram_responder
  import xfab_pkg::*;
#(
  parameter int             AW              = DEF_AW,
  parameter int             DW              = DEF_DW,
  parameter int             MEM_AW          = 8,
  parameter int             LATENCY         = 1,
  parameter int             OUTSTANDING_NUM = 2,
  parameter logic [DW-1:0]  ERR_DAT         = DW'(16'hDEAD),
  localparam int            SW              = strb_w(DW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_vld,
  input  logic          req_wr,
  input  logic [AW-1:0] req_adr,
  input  logic [SW-1:0] req_strb,
  input  logic [DW-1:0] req_dat,
  output logic          req_gnt,
  output logic          rsp_vld,
  output logic [DW-1:0] rsp_dat,
  input  logic          rsp_gnt,
  output logic          err
);

  localparam int DEPTH = 2 ** MEM_AW;
  localparam int CW    = $clog2(OUTSTANDING_NUM + 1);

  typedef struct packed {
    logic          vld;
    logic [DW-1:0] dat;
  } pipe_t;

  logic [DW-1:0]     mem_q [DEPTH];
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              accept, rsp_hs, in_range;
  logic [MEM_AW-1:0] widx;
  pipe_t             acc_entry, push_entry;
  logic              fifo_full, fifo_empty;
  logic [DW-1:0]     fifo_head;

  // cnt covers every accepted-but-unreturned request, pipeline and FIFO alike.
  assign req_gnt = !rst && (cnt_q < CW'(OUTSTANDING_NUM));
  assign accept  = req_vld && req_gnt;
  assign rsp_vld = !rst && !fifo_empty;
  assign rsp_hs  = rsp_vld && rsp_gnt;
  assign rsp_dat = rsp_vld ? fifo_head : '0;
  assign err     = !rst && err_q;
  assign widx    = MEM_AW'(req_adr);

  if (MEM_AW < AW) begin : g_range
    assign in_range = (req_adr[AW-1:MEM_AW] == '0);
  end else begin : g_all_in
    assign in_range = 1'b1;
  end

  always_comb begin
    acc_entry.vld = accept;
    acc_entry.dat = '0;
    if (!req_wr) acc_entry.dat = in_range ? mem_q[widx] : ERR_DAT;
  end

  // NOTE: the memory array has no reset; contents survive rst by design and
  // resetting it would turn the array into a huge reset fan-out.
  always_ff @(posedge clk) begin
    if (accept && req_wr && in_range) begin
      for (int i = 0; i < SW; i++) begin
        if (req_strb[i]) mem_q[widx][8*i +: 8] <= req_dat[8*i +: 8];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !rsp_hs)      cnt_d = cnt_q + 1'b1;
    else if (!accept && rsp_hs) cnt_d = cnt_q - 1'b1;
    err_d = accept && !in_range;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  if (LATENCY == 1) begin : g_no_pipe
    assign push_entry = acc_entry;
  end else begin : g_pipe
    pipe_t pipe_q [LATENCY-1];
    pipe_t pipe_d [LATENCY-1];

    always_comb begin
      pipe_d[0] = acc_entry;
      for (int s = 1; s < LATENCY - 1; s++) pipe_d[s] = pipe_q[s-1];
    end

    always_ff @(posedge clk) begin
      for (int s = 0; s < LATENCY - 1; s++) begin
        if (rst) pipe_q[s] <= '0;
        else     pipe_q[s] <= pipe_d[s];
      end
    end

    assign push_entry = pipe_q[LATENCY-2];
  end

  xfab_sync_fifo #(
    .W     (DW),
    .DEPTH (OUTSTANDING_NUM)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_entry.vld),
    .push_dat (push_entry.dat),
    .pop      (rsp_hs),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_entry.vld && fifo_full && !rsp_hs));

endmodule

// File: tb/tb_xslv_sram_responder.sv
// Bench for xslv_sram_responder: directed vector table, multi-cycle corner
// sequences and randomized traffic against a queue-based reference model.
module tb_xslv_sram_responder;
  import xfab_pkg::*;

  localparam int          LAT_A = 1;
  localparam int          OUT_A = 2;
  localparam logic [15:0] ERR_V = 16'hDEAD;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_vld, req_wr, req_gnt, rsp_vld, rsp_gnt, err;
  logic [15:0] req_adr, req_dat, rsp_dat;
  logic [1:0]  req_strb;
  logic        b_req_vld, b_req_wr, b_req_gnt, b_rsp_vld, b_rsp_gnt, b_err;
  logic [15:0] b_req_adr, b_req_dat, b_rsp_dat;
  logic [1:0]  b_req_strb;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  xslv_sram_responder #(.LATENCY(LAT_A), .OUTSTANDING_NUM(OUT_A)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_wr(req_wr), .req_adr(req_adr),
    .req_strb(req_strb), .req_dat(req_dat), .req_gnt(req_gnt), .rsp_vld(rsp_vld),
    .rsp_dat(rsp_dat), .rsp_gnt(rsp_gnt), .err(err)
  );

  xslv_sram_responder #(.LATENCY(3), .OUTSTANDING_NUM(4)) dut3 (
    .clk(clk), .rst(rst), .req_vld(b_req_vld), .req_wr(b_req_wr), .req_adr(b_req_adr),
    .req_strb(b_req_strb), .req_dat(b_req_dat), .req_gnt(b_req_gnt), .rsp_vld(b_rsp_vld),
    .rsp_dat(b_rsp_dat), .rsp_gnt(b_rsp_gnt), .err(b_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] iv(input int a);
    return 16'((a & 255) * 257) ^ 16'h3C5A;
  endfunction

  // Reference model: memory image plus queue of expected responses, each
  // tagged with the earliest cycle it may appear.
  typedef struct { rsp_entry_t e; int ready; } exp_t;
  exp_t        mq[$];
  logic [15:0] mmem [256];
  bit          prev_oor = 1'b0;

  always @(negedge clk) begin : model
    logic exp_gnt, exp_vld, oor;
    logic [15:0] d;
    exp_t ent;
    if (rst) begin
      check("rst_req_gnt", 32'(req_gnt), 0);
      check("rst_rsp_vld", 32'(rsp_vld), 0);
      check("rst_rsp_dat", 32'(rsp_dat), 0);
      check("rst_err", 32'(err), 0);
      mq.delete();
      prev_oor = 1'b0;
    end else begin
      exp_gnt = (mq.size() < OUT_A);
      exp_vld = 1'b0;
      if (mq.size() > 0) exp_vld = (mq[0].ready <= cyc);
      check("m_req_gnt", 32'(req_gnt), 32'(exp_gnt));
      check("m_rsp_vld", 32'(rsp_vld), 32'(exp_vld));
      check("m_err", 32'(err), 32'(prev_oor));
      if (exp_vld) begin
        check("m_rsp_dat", 32'(rsp_dat), 32'(mq[0].e.dat));
        if (rsp_gnt) void'(mq.pop_front());
      end
      prev_oor = 1'b0;
      if (req_vld && exp_gnt) begin
        oor = (req_adr[15:8] != 8'h00);
        if (req_wr) begin
          d = '0;
          if (!oor) begin
            for (int b = 0; b < 2; b++)
              if (req_strb[b]) mmem[req_adr[7:0]][8*b +: 8] = req_dat[8*b +: 8];
          end
        end else begin
          d = oor ? ERR_V : mmem[req_adr[7:0]];
        end
        ent.e.dat = d;
        ent.ready = cyc + LAT_A;
        mq.push_back(ent);
        prev_oor = oor;
      end
    end
  end

  typedef struct { int cyc; logic [15:0] dat; } blog_t;
  blog_t b_log[$];

  always @(negedge clk) begin : b_mon
    blog_t x;
    if (!rst && b_rsp_vld && b_rsp_gnt) begin
      x.cyc = cyc;
      x.dat = b_rsp_dat;
      b_log.push_back(x);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [15:0] adr, input logic [1:0] strb,
                       input logic [15:0] dat);
    int n;
    req_vld = 1'b1; req_wr = wr; req_adr = adr; req_strb = strb; req_dat = dat;
    n = 0;
    @(negedge clk);
    while (!req_gnt && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("issue_gnt", 32'(req_gnt), 1);
    tick();
    req_vld = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] adr;
    logic [1:0]  strb;
    logic [15:0] dat;
    logic [15:0] exp_dat;
    logic        exp_err;
  } vec_t;
  vec_t tv [13];

  initial begin
    bit   acc;
    int   t0;
    tv[0]  = '{1'b1, 16'h0010, 2'b11, 16'hA5C3, 16'h0000, 1'b0};
    tv[1]  = '{1'b0, 16'h0010, 2'b00, 16'h0000, 16'hA5C3, 1'b0};
    tv[2]  = '{1'b1, 16'h0010, 2'b01, 16'h1122, 16'h0000, 1'b0};
    tv[3]  = '{1'b0, 16'h0010, 2'b00, 16'h0000, 16'hA522, 1'b0};
    tv[4]  = '{1'b1, 16'h0010, 2'b00, 16'hFFFF, 16'h0000, 1'b0};
    tv[5]  = '{1'b0, 16'h0010, 2'b00, 16'h0000, 16'hA522, 1'b0};
    tv[6]  = '{1'b0, 16'h0100, 2'b00, 16'h0000, 16'hDEAD, 1'b1};
    tv[7]  = '{1'b1, 16'h0100, 2'b11, 16'h5555, 16'h0000, 1'b1};
    tv[8]  = '{1'b0, 16'h0000, 2'b00, 16'h0000, 16'h3C5A, 1'b0};
    tv[9]  = '{1'b1, 16'h0055, 2'b10, 16'hBEEF, 16'h0000, 1'b0};
    tv[10] = '{1'b0, 16'h0055, 2'b00, 16'h0000, 16'hBE0F, 1'b0};
    tv[11] = '{1'b0, 16'hFFFF, 2'b00, 16'h0000, 16'hDEAD, 1'b1};
    tv[12] = '{1'b0, 16'h00FF, 2'b00, 16'h0000, 16'hC3A5, 1'b0};

    rst = 1'b1;
    req_vld = 0; req_wr = 0; req_adr = 0; req_strb = 0; req_dat = 0; rsp_gnt = 0;
    b_req_vld = 0; b_req_wr = 0; b_req_adr = 0; b_req_strb = 0; b_req_dat = 0; b_rsp_gnt = 0;
    repeat (3) tick();
    @(negedge clk);
    check("reset_req_gnt", 32'(req_gnt), 0);
    check("reset_rsp_vld", 32'(rsp_vld), 0);
    check("reset_b_req_gnt", 32'(b_req_gnt), 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_gnt", 32'(req_gnt), 1);
    check("post_reset_vld", 32'(rsp_vld), 0);
    tick();

    // Known memory image for every in-range word.
    rsp_gnt = 1'b1;
    for (int a = 0; a < 256; a++) issue(1'b1, 16'(a), 2'b11, iv(a));
    repeat (3) tick();

    for (int i = 0; i < 13; i++) begin
      issue(tv[i].wr, tv[i].adr, tv[i].strb, tv[i].dat);
      @(negedge clk);
      check($sformatf("vec%0d_vld", i), 32'(rsp_vld), 1);
      check($sformatf("vec%0d_dat", i), 32'(rsp_dat), 32'(tv[i].exp_dat));
      check($sformatf("vec%0d_err", i), 32'(err), 32'(tv[i].exp_err));
      tick();
    end
    tick();

    // Backpressure: two accepts, then grant held low until a handshake.
    rsp_gnt = 1'b0;
    req_vld = 1'b1; req_wr = 1'b0; req_adr = 16'h0030;
    @(negedge clk); check("bp_gnt_a0", 32'(req_gnt), 1); tick();
    req_adr = 16'h0031;
    @(negedge clk); check("bp_gnt_a1", 32'(req_gnt), 1); tick();
    req_adr = 16'h0032;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_hold_gnt", 32'(req_gnt), 0);
      check("bp_hold_dat", 32'(rsp_dat), 32'(iv(8'h30)));
      tick();
    end
    rsp_gnt = 1'b1;
    @(negedge clk); check("bp_hs_gnt", 32'(req_gnt), 0); tick();
    @(negedge clk);
    check("bp_regnt", 32'(req_gnt), 1);
    check("bp_second_dat", 32'(rsp_dat), 32'(iv(8'h31)));
    tick();
    req_adr = 16'h0033;
    @(negedge clk); check("bp_gnt_a3", 32'(req_gnt), 1); tick();
    req_vld = 1'b0;
    repeat (4) tick();

    // Latency 3 / depth 4 instance: streaming writes then streaming reads.
    b_rsp_gnt = 1'b1;
    for (int k = 0; k < 8; k++) begin
      b_req_vld = 1'b1; b_req_wr = 1'b1; b_req_adr = 16'(k * 3);
      b_req_strb = 2'b11; b_req_dat = 16'(16'h7000 + k);
      @(negedge clk); check("l3_wr_gnt", 32'(b_req_gnt), 1); tick();
    end
    b_req_vld = 1'b0;
    repeat (8) tick();
    b_log.delete();
    t0 = 0;
    for (int k = 0; k < 8; k++) begin
      b_req_vld = 1'b1; b_req_wr = 1'b0; b_req_adr = 16'(k * 3);
      @(negedge clk);
      check("l3_rd_gnt", 32'(b_req_gnt), 1);
      if (k == 0) t0 = cyc;
      tick();
    end
    b_req_vld = 1'b0;
    repeat (8) tick();
    check("l3_rsp_count", 32'(b_log.size()), 8);
    for (int k = 0; k < b_log.size(); k++) begin
      check("l3_rsp_cycle", 32'(b_log[k].cyc), 32'(t0 + 3 + k));
      check("l3_rsp_dat", 32'(b_log[k].dat), 32'(16'h7000 + k));
    end

    // Randomized traffic; the model checks every cycle.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      acc = req_vld && req_gnt;
      tick();
      if (acc || !req_vld) begin
        req_vld  = ($urandom_range(0, 3) != 0);
        req_wr   = 1'($urandom_range(0, 1));
        req_adr  = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(256, 65535))
                                                : 16'($urandom_range(0, 31));
        req_strb = 2'($urandom_range(0, 3));
        req_dat  = 16'($urandom);
      end
      rsp_gnt = ($urandom_range(0, 3) != 0);
    end
    req_vld = 1'b0;
    rsp_gnt = 1'b1;
    repeat (10) tick();
    @(negedge clk); check("rand_drained", 32'(rsp_vld), 0);
    tick();

    // Reset with two responses outstanding.
    issue(1'b1, 16'h0020, 2'b11, 16'h1357);
    repeat (2) tick();
    rsp_gnt = 1'b0;
    issue(1'b0, 16'h0021, 2'b00, 16'h0000);
    issue(1'b0, 16'h0022, 2'b00, 16'h0000);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_vld", 32'(rsp_vld), 0);
    check("midrst_gnt", 32'(req_gnt), 0);
    tick();
    rst = 1'b0;
    rsp_gnt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("midrst_no_stale", 32'(rsp_vld), 0);
      tick();
    end
    issue(1'b0, 16'h0020, 2'b00, 16'h0000);
    @(negedge clk);
    check("midrst_read_vld", 32'(rsp_vld), 1);
    check("midrst_read_dat", 32'(rsp_dat), 32'h1357);
    tick();
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
